// File: rtl/sr_chk_pkg.sv
// sr_chk_pkg: shared FSM states, counter width, invalid SR encoding and saturating increment
package sr_chk_pkg;
  localparam int CNT_W = 4;
  localparam logic [1:0] SR_INV = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sr_t_ref.sv
// sr_t_ref: golden SR-to-T conversion, flags the illegal S=R=1 input
module sr_t_ref
  import sr_chk_pkg::*;
(
  input  logic s,
  input  logic r,
  input  logic q,
  output logic t_exp,
  output logic inv
);
  assign inv   = {s, r} == SR_INV;
  assign t_exp = (s & ~r) ? ~q : (~s & r) ? q : 1'b0;
endmodule

// File: rtl/sr_t_checker.sv
// sr_t_checker: sweeps SR-to-T converter vectors against sr_t_ref and tallies results.
// Define SR_CHK_STOP_ON_FAIL_EN to freeze in HALT on the first mismatch.
module sr_t_checker
  import sr_chk_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int ORDERED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  input  logic             vec_s,
  input  logic             vec_r,
  input  logic             vec_q,
  input  logic             vec_t,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic             order_err,
  output logic             done,
  output logic             pass
);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(NUM_VEC - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d, pass_q, pass_d, fail_q, fail_d, inv_q, inv_d;
  logic oerr_q, oerr_d;
  logic t_exp, inv, acc, mis, ord_bad, nxt_done;
  sr_t_ref u_ref (
    .s    (vec_s),
    .r    (vec_r),
    .q    (vec_q),
    .t_exp(t_exp),
    .inv  (inv)
  );
  always_comb begin
    acc      = vec_valid && (state_q == IDLE || state_q == RUN);
    mis      = acc && !inv && (vec_t != t_exp);
    ord_bad  = acc && (ORDERED != 0) && (CNT_W'({vec_s, vec_r, vec_q}) != pos_q);
    nxt_done = pos_q == LAST_POS;
    pos_d    = acc ? pos_q + 1'b1 : pos_q;
    pass_d   = (acc && !inv && !mis) ? sat_inc(pass_q) : pass_q;
    fail_d   = mis ? sat_inc(fail_q) : fail_q;
    inv_d    = (acc && inv) ? sat_inc(inv_q) : inv_q;
    oerr_d   = oerr_q | ord_bad;
`ifdef SR_CHK_STOP_ON_FAIL_EN
    state_d  = !acc ? state_q : mis ? HALT : nxt_done ? DONE : RUN;
`else
    state_d  = !acc ? state_q : nxt_done ? DONE : RUN;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      inv_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      inv_q   <= inv_d;
      oerr_q  <= oerr_d;
    end
  end
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign inv_cnt   = inv_q;
  assign order_err = oerr_q;
  assign done      = state_q == DONE;
  assign pass      = done && fail_q == '0 && !oerr_q;
endmodule

// File: tb/tb_sr_t_checker.sv
// tb_sr_t_checker: scoreboard bench for the default sweep checker and a 15-vector unordered instance
module tb_sr_t_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic va = 1'b0, vb = 1'b0, vs = 1'b0, vr = 1'b0, vq = 1'b0, vt = 1'b0;
  logic [3:0] a_pass, a_fail, a_inv, b_pass, b_fail, b_inv;
  logic a_oerr, a_done, a_ps, b_oerr, b_done, b_ps;
  logic tgt = 1'b0;
  int checks = 0, errors = 0;
  int m_n = 8, m_ord = 1, m_pos, m_pass, m_fail, m_inv;
  logic m_oerr, m_done, m_halt;
  typedef struct {int p; int f; int i; logic o; logic d; logic ps;} sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  sr_t_checker u_dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(va), .vec_s(vs), .vec_r(vr), .vec_q(vq), .vec_t(vt),
    .pass_cnt(a_pass), .fail_cnt(a_fail), .inv_cnt(a_inv), .order_err(a_oerr), .done(a_done), .pass(a_ps)
  );
  sr_t_checker #(.NUM_VEC(15), .ORDERED(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .vec_valid(vb), .vec_s(vs), .vec_r(vr), .vec_q(vq), .vec_t(vt),
    .pass_cnt(b_pass), .fail_cnt(b_fail), .inv_cnt(b_inv), .order_err(b_oerr), .done(b_done), .pass(b_ps)
  );

  function automatic logic ref_t(input logic [2:0] srq);
    case (srq[2:1])
      2'b00: return 1'b0;
      2'b01: return srq[0];
      2'b10: return ~srq[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return v >= 15 ? 15 : v + 1;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs(input sb_t e);
    check("pass_cnt", tgt ? b_pass : a_pass, e.p);
    check("fail_cnt", tgt ? b_fail : a_fail, e.f);
    check("inv_cnt", tgt ? b_inv : a_inv, e.i);
    check("order_err", tgt ? b_oerr : a_oerr, e.o);
    check("done", tgt ? b_done : a_done, e.d);
    check("pass", tgt ? b_ps : a_ps, e.ps);
  endtask

  task automatic model_clear();
    m_pos = 0; m_pass = 0; m_fail = 0; m_inv = 0;
    m_oerr = 1'b0; m_done = 1'b0; m_halt = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] srq, input logic t);
    sb_t e;
    @(negedge clk);
    {vs, vr, vq} = srq;
    vt = t;
    va = v && !tgt;
    vb = v && tgt;
    if (v && !m_done && !m_halt) begin
      if (srq[2] && srq[1]) m_inv = sat(m_inv);
      else if (t == ref_t(srq)) m_pass = sat(m_pass);
      else begin
        m_fail = sat(m_fail);
`ifdef SR_CHK_STOP_ON_FAIL_EN
        m_halt = 1'b1;
`endif
      end
      if (m_ord != 0 && int'(srq) != m_pos) m_oerr = 1'b1;
      m_pos++;
      if (m_pos == m_n && !m_halt) m_done = 1'b1;
    end
    e = '{m_pass, m_fail, m_inv, m_oerr, m_done, m_done && m_fail == 0 && !m_oerr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
    compare_outputs(sb.pop_front());
  endtask

  // A legal vector is presented during reset; it must not be counted.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {vs, vr, vq} = 3'b000;
    vt = 1'b0;
    va = 1'b1;
    vb = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    va = 1'b0;
    vb = 1'b0;
    model_clear();
    compare_outputs('{0, 0, 0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic sweep(input int gaps, input int bad_idx, input logic swap23);
    logic [2:0] srq;
    for (int i = 0; i < 8; i++) begin
      srq = 3'(i);
      if (swap23 && i == 2) srq = 3'd3;
      if (swap23 && i == 3) srq = 3'd2;
      drive(1'b1, srq, (i == bad_idx) ? ~ref_t(srq) : ref_t(srq));
      for (int g = 0; g < gaps; g++) drive(1'b0, 3'b000, 1'b0);
    end
  endtask

  initial begin
    model_clear();
    do_reset();
    sweep(0, -1, 1'b0);
    check("full_pass_cnt", a_pass, 6);
    check("full_pass", a_ps, 1);
    drive(1'b1, 3'b100, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    do_reset();
    sweep(0, 4, 1'b0);
    do_reset();
    sweep(0, -1, 1'b1);
    do_reset();
    sweep(3, -1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), ref_t(3'(i)));
    do_reset();
    sweep(0, -1, 1'b0);
    tgt = 1'b1;
    m_n = 15;
    m_ord = 0;
    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b1, 3'b000, 1'b0);
    check("sat_pass_cnt", b_pass, 15);
    check("sat_done", b_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_t_checker.md
SR_T_CHECKER -- requirements
Module: sr_t_checker

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 8, giving the number of vectors in one sweep (2..15).
REQ-002 The block SHALL have parameter ORDERED, default 1; when 1, each vector index {s,r,q} must equal the sweep position.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 vec_valid  input  1  vec_s/vec_r/vec_q/vec_t hold a vector this cycle.
REQ-006 vec_s  input  1  S stimulus applied to the SR-to-T converter under test.
REQ-007 vec_r  input  1  R stimulus.
REQ-008 vec_q  input  1  present-state Q stimulus.
REQ-009 vec_t  input  1  T output observed from the converter under test.
REQ-010 pass_cnt  output  4  count of vectors checked and matching.
REQ-011 fail_cnt  output  4  count of legal vectors that mismatch.
REQ-012 inv_cnt  output  4  count of S=R=1 vectors (not checked).
REQ-013 order_err  output  1  sticky; set on an out-of-sequence vector.
REQ-014 done  output  1  high in DONE state.
REQ-015 pass  output  1  high in DONE when fail_cnt==0 and order_err==0.

Function
REQ-016 Expected T SHALL follow: SR=00 -> 0; SR=01 -> q; SR=10 -> ~q; SR=11 -> invalid, no expected value.
REQ-017 FSM states SHALL be IDLE, RUN, DONE, HALT.
REQ-018 IDLE -> RUN on the first vec_valid; that vector SHALL be checked in the same cycle it is accepted.
REQ-019 Each accepted vector SHALL update exactly one of pass_cnt, fail_cnt, inv_cnt, visible on the following cycle (1-cycle latency).
REQ-020 The sweep position counter SHALL increment per accepted vector; when it reaches NUM_VEC the FSM SHALL enter DONE.
REQ-021 When ORDERED=1 and {vec_s,vec_r,vec_q} != position, order_err SHALL set; the vector SHALL still be checked.
REQ-022 vec_valid low SHALL leave all counters and state unchanged (gaps allowed).
REQ-023 Counters SHALL saturate at 15, never wrap.
REQ-024 In DONE, inputs SHALL be ignored; done and pass SHALL hold until reset.
REQ-025 done and pass SHALL be low in every state except DONE.

Reset
REQ-026 With rst_n low at a rising edge: state=IDLE, position=0, all counters=0, order_err=0, done=0, pass=0.
REQ-027 Reset asserted mid-sweep SHALL discard the partial sweep; the vector present in the reset cycle SHALL NOT be counted.

Configuration
REQ-028 Macro SR_CHK_STOP_ON_FAIL_EN: when defined, the first mismatch SHALL move the FSM to HALT (counters frozen, done=0, pass=0) until reset; when undefined, HALT SHALL be unreachable and checking SHALL continue to DONE.

Structure
REQ-029 Package sr_chk_pkg SHALL hold the FSM state enum, the counter width constant (4) and the invalid-combination encoding.
REQ-030 Sub-module sr_t_ref SHALL compute expected T and an invalid flag from s, r, q combinationally; sr_t_checker SHALL instantiate it once.

Verification
REQ-031 Full sweep: 8 vectors 000..111 with correct T (0,0,0,1,1,0,x,x) -> pass_cnt=6, inv_cnt=2, fail_cnt=0, done=1, pass=1.
REQ-032 Mismatch: vector SR=10,q=0 with t=0 -> fail_cnt=1, pass=0 at DONE; with SR_CHK_STOP_ON_FAIL_EN -> HALT, done stays 0.
REQ-033 Out of order: swap vectors 2 and 3 (ORDERED=1) -> order_err=1, pass_cnt=6, pass=0.
REQ-034 Gaps: vec_valid low for 3 cycles between every vector -> same counts as REQ-031, done only after 8th valid.
REQ-035 Reset after 4 vectors, then full sweep -> pass_cnt=6, inv_cnt=2, pass=1.
REQ-036 Saturation: NUM_VEC=15, ORDERED=0, 15 copies of SR=00,q=0,t=0 -> pass_cnt=15, done=1; extra vectors after DONE ignored.
